// File: rtl/mem_access_ctrl_pkg.sv
// Shared size codes and FSM state encoding for the MEM-stage data-SRAM access controller.
package mem_access_ctrl_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/mem_access_ctrl_align.sv
// Combinational byte-lane helper: store strobes/replication, misalign detect, and
// load extraction/extension from the latched access.
module mem_access_ctrl_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_addr_lo,
    input  logic        ld_sign,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic        misaligned,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        wstrb      = 4'b1111;
        wdata_rep  = st_wdata;
        misaligned = 1'b0;
        case (st_size)
            SZ_B: begin
                wstrb     = 4'b0001 << st_addr_lo;
                wdata_rep = {4{st_wdata[7:0]}};
            end
            SZ_H: begin
                wstrb      = 4'b0011 << st_addr_lo;
                wdata_rep  = {2{st_wdata[15:0]}};
                misaligned = st_addr_lo[0];
            end
            default: begin
                misaligned = (st_addr_lo != 2'b00);
            end
        endcase
    end

    // The addressed byte/half is shifted down to bit 0 before extension.
    always_comb begin
        shifted = rdata >> {ld_addr_lo, 3'b000};
        case (ld_size)
            SZ_B:    load_data = {{24{ld_sign & shifted[7]}}, shifted[7:0]};
            SZ_H:    load_data = {{16{ld_sign & shifted[15]}}, shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-SRAM sequencer: one load/store per instruction over req/addr_ok/data_ok,
// stalling the pipeline until the access completes or is drained after a flush.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stallreq,
    output logic              load_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              err_ale,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [3:0]        data_sram_wstrb,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [DATA_W-1:0] data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    output logic [2:0]        dbg_state
);

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              sign_q, sign_d;
    logic              load_valid_q, load_valid_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic              err_ale_q, err_ale_d;

    logic              accept;
    logic [3:0]        al_wstrb;
    logic [DATA_W-1:0] al_wdata;
    logic              al_misaligned;
    logic [DATA_W-1:0] al_load;

    mem_access_ctrl_align u_align (
        .st_size    (req_size),
        .st_addr_lo (req_addr[1:0]),
        .st_wdata   (req_wdata),
        .ld_size    (size_q),
        .ld_addr_lo (addr_q[1:0]),
        .ld_sign    (sign_q),
        .rdata      (data_sram_rdata),
        .wstrb      (al_wstrb),
        .wdata_rep  (al_wdata),
        .misaligned (al_misaligned),
        .load_data  (al_load)
    );

    // Handshake: data_sram_req stays high with stable fields until the cycle addr_ok is seen;
    // exactly one data_ok follows each accepted request, even if the op was flushed.
    always_comb begin
        state_d      = state_q;
        stallreq     = 1'b0;
        accept       = 1'b0;
        err_ale_d    = 1'b0;
        load_valid_d = 1'b0;
        load_data_d  = load_data_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    if (al_misaligned) begin
                        err_ale_d = 1'b1;
                    end else begin
                        accept   = 1'b1;
                        stallreq = 1'b1;
                        state_d  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stallreq = 1'b1;
                if (data_sram_addr_ok) begin
                    if (data_sram_data_ok) state_d = flush ? ST_IDLE : ST_DONE;
                    else                   state_d = flush ? ST_DRAIN : ST_WAIT;
                end else if (flush) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                stallreq = 1'b1;
                if (flush)                  state_d = data_sram_data_ok ? ST_IDLE : ST_DRAIN;
                else if (data_sram_data_ok) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_DRAIN: begin
                stallreq = 1'b1;
                if (data_sram_data_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_d == ST_DONE) && (state_q != ST_DONE) && !wr_q) begin
            load_valid_d = 1'b1;
            load_data_d  = al_load;
        end

        req_d   = (state_d == ST_REQ);
        wr_d    = accept ? req_we : wr_q;
        size_d  = accept ? req_size : size_q;
        sign_d  = accept ? req_sign : sign_q;
        addr_d  = accept ? req_addr : addr_q;
        wdata_d = accept ? al_wdata : wdata_q;
        wstrb_d = accept ? (req_we ? al_wstrb : 4'b0000) : wstrb_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            wr_q         <= 1'b0;
            size_q       <= 2'b00;
            wstrb_q      <= 4'b0000;
            addr_q       <= '0;
            wdata_q      <= '0;
            sign_q       <= 1'b0;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
            err_ale_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            wstrb_q      <= wstrb_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            sign_q       <= sign_d;
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
            err_ale_q    <= err_ale_d;
        end
    end

    assign load_valid      = load_valid_q;
    assign load_data       = load_data_q;
    assign err_ale         = err_ale_q;
    assign data_sram_req   = req_q;
    assign data_sram_wr    = wr_q;
    assign data_sram_size  = size_q;
    assign data_sram_wstrb = wstrb_q;
    assign data_sram_addr  = addr_q;
    assign data_sram_wdata = wdata_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: bus slave responses driven by hand, expected values
// hand-computed from byte-lane arithmetic.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_sign = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        stallreq;
    logic        load_valid;
    logic [31:0] load_data;
    logic        err_ale;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok = 1'b0;
    logic        data_sram_data_ok = 1'b0;
    logic [31:0] data_sram_rdata = '0;
    logic [2:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .req_valid         (req_valid),
        .req_we            (req_we),
        .req_size          (req_size),
        .req_sign          (req_sign),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .stallreq          (stallreq),
        .load_valid        (load_valid),
        .load_data         (load_data),
        .err_ale           (err_ale),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .dbg_state         (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; slave answers addr_ok and data_ok in the first REQ cycle.
    task automatic do_fast(input string tag, input logic we, input logic [1:0] sz, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                           input logic [31:0] exp_ld, input logic [3:0] exp_strb,
                           input logic [31:0] exp_wd);
        req_valid = 1'b1; req_we = we; req_size = sz; req_sign = sgn;
        req_addr = addr; req_wdata = wd;
        #1 chk({tag, ".stall_accept"}, stallreq, 1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk({tag, ".req"}, data_sram_req, 1);
        chk({tag, ".wr"}, data_sram_wr, we);
        chk({tag, ".size"}, data_sram_size, sz);
        chk({tag, ".addr"}, data_sram_addr, addr);
        chk({tag, ".wstrb"}, data_sram_wstrb, exp_strb);
        chk({tag, ".wdata"}, data_sram_wdata, exp_wd);
        chk({tag, ".stall_req"}, stallreq, 1);
        data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = rd;
        @(negedge clk);
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
        #1;
        chk({tag, ".state_done"}, dbg_state, ST_DONE);
        chk({tag, ".load_valid"}, load_valid, !we);
        chk({tag, ".load_data"}, load_data, exp_ld);
        chk({tag, ".stall_done"}, stallreq, 0);
        chk({tag, ".req_done"}, data_sram_req, 0);
        @(negedge clk);
        #1;
        chk({tag, ".load_valid_off"}, load_valid, 0);
        chk({tag, ".state_idle"}, dbg_state, ST_IDLE);
    endtask

    task automatic do_misaligned(input string tag, input logic we, input logic [1:0] sz,
                                 input logic [31:0] addr);
        req_valid = 1'b1; req_we = we; req_size = sz; req_addr = addr; req_wdata = 32'h5555_AAAA;
        #1 chk({tag, ".stall"}, stallreq, 0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk({tag, ".err_ale"}, err_ale, 1);
        chk({tag, ".req"}, data_sram_req, 0);
        chk({tag, ".stall_after"}, stallreq, 0);
        @(negedge clk);
        #1;
        chk({tag, ".err_off"}, err_ale, 0);
        chk({tag, ".req_off"}, data_sram_req, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst.req", data_sram_req, 0);
        chk("rst.stall", stallreq, 0);
        chk("rst.load_valid", load_valid, 0);
        chk("rst.load_data", load_data, 0);
        chk("rst.err", err_ale, 0);
        chk("rst.state", dbg_state, ST_IDLE);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        //       tag    we    size  sgn   addr          wdata         rdata         exp_ld        strb     wdata_bus
        do_fast("lw",   1'b0, SZ_W, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b0000, 32'h0);
        do_fast("lb",   1'b0, SZ_B, 1'b1, 32'h0000_0103, 32'h0,        32'h8011_2233, 32'hFFFF_FF80, 4'b0000, 32'h0);
        do_fast("lhu",  1'b0, SZ_H, 1'b0, 32'h0000_0102, 32'h0,        32'h8011_2233, 32'h0000_8011, 4'b0000, 32'h0);
        do_fast("lbu",  1'b0, SZ_B, 1'b0, 32'h0000_0101, 32'h0,        32'h8011_2233, 32'h0000_0022, 4'b0000, 32'h0);
        do_fast("lh",   1'b0, SZ_H, 1'b1, 32'h0000_0100, 32'h0,        32'h1234_F00D, 32'hFFFF_F00D, 4'b0000, 32'h0);
        do_fast("sb",   1'b1, SZ_B, 1'b0, 32'h0000_0101, 32'h0000_00AB, 32'h0,        32'hFFFF_F00D, 4'b0010, 32'hABAB_ABAB);
        do_fast("sh",   1'b1, SZ_H, 1'b0, 32'h0000_0102, 32'h0000_1234, 32'h0,        32'hFFFF_F00D, 4'b1100, 32'h1234_1234);
        do_fast("sw",   1'b1, SZ_W, 1'b0, 32'h0000_0104, 32'h1122_3344, 32'h0,        32'hFFFF_F00D, 4'b1111, 32'h1122_3344);

        do_misaligned("sw_mis", 1'b1, SZ_W, 32'h0000_0102);
        do_misaligned("lh_mis", 1'b0, SZ_H, 32'h0000_0101);

        // Slow slave: addr_ok in the 3rd REQ cycle, data_ok in the 4th WAIT cycle.
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_sign = 1'b0; req_addr = 32'h0000_0200;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("slow.req", data_sram_req, 1);
            chk("slow.addr", data_sram_addr, 32'h0000_0200);
            chk("slow.size", data_sram_size, SZ_W);
            chk("slow.stall_req", stallreq, 1);
            if (i == 2) data_sram_addr_ok = 1'b1;
            @(negedge clk);
        end
        data_sram_addr_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("slow.req_wait", data_sram_req, 0);
            chk("slow.stall_wait", stallreq, 1);
            chk("slow.no_lv", load_valid, 0);
            if (i == 3) begin data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D; end
            @(negedge clk);
        end
        data_sram_data_ok = 1'b0;
        #1;
        chk("slow.load_valid", load_valid, 1);
        chk("slow.load_data", load_data, 32'hCAFE_F00D);
        chk("slow.stall_done", stallreq, 0);
        @(negedge clk);
        #1 chk("slow.lv_single", load_valid, 0);

        // Flush while waiting for data: response is drained and discarded.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0300; req_size = SZ_W; req_we = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; data_sram_addr_ok = 1'b1;
        @(negedge clk);
        data_sram_addr_ok = 1'b0; flush = 1'b1;
        #1 chk("fl_wait.stall", stallreq, 1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_wait.state_drain", dbg_state, ST_DRAIN);
        chk("fl_wait.stall_drain", stallreq, 1);
        chk("fl_wait.req", data_sram_req, 0);
        @(negedge clk);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_2222;
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        chk("fl_wait.no_lv", load_valid, 0);
        chk("fl_wait.stall_idle", stallreq, 0);
        chk("fl_wait.state_idle", dbg_state, ST_IDLE);
        chk("fl_wait.load_hold", load_data, 32'hCAFE_F00D);

        // Flush in REQ before addr_ok: request withdrawn.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0304;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b1;
        #1 chk("fl_req.req_held", data_sram_req, 1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_req.req_drop", data_sram_req, 0);
        chk("fl_req.stall", stallreq, 0);

        // Flush on the same cycle as req_valid: nothing accepted.
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1;
        #1 chk("fl_acc.stall", stallreq, 0);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        #1 chk("fl_acc.req", data_sram_req, 0);

        // Reset during REQ clears the bus request immediately.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0400;
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk("rst_req.req_before", data_sram_req, 1);
        #1 rst = 1'b0;
        #1;
        chk("rst_req.req", data_sram_req, 0);
        chk("rst_req.stall", stallreq, 0);
        chk("rst_req.load_data", load_data, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_fast("lw_after_rst", 1'b0, SZ_W, 1'b0, 32'h0000_0408, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'b0000, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
